// File: rtl/smi_target_if.sv
// MDIO/SMI management bus bundle between a station (master side) and the
// PHY-side target.
//
// Handshake: there is no valid/ready pair on this bus. mdc_i/mdio_i are raw
// asynchronous pad signals. rd_stb_o, wr_stb_o and err_o are single-clk
// strobes with no back-pressure. rd_adr_o is valid in the rd_stb_o cycle and
// stays valid afterwards. rd_data_i must be stable by the next MDC rising edge.
// wr_data_o/rd_adr_o are valid in the wr_stb_o cycle.
interface smi_target_if;
    logic        mdc_i;
    logic        mdio_i;
    logic        mdio_oe_o;
    logic        rd_stb_o;
    logic [4:0]  rd_adr_o;
    logic [15:0] rd_data_i;
    logic        wr_stb_o;
    logic [15:0] wr_data_o;
    logic        busy_o;
    logic        err_o;

    modport master (
        output mdc_i, mdio_i, rd_data_i,
        input  mdio_oe_o, rd_stb_o, rd_adr_o, wr_stb_o, wr_data_o, busy_o, err_o
    );

    modport slave (
        input  mdc_i, mdio_i, rd_data_i,
        output mdio_oe_o, rd_stb_o, rd_adr_o, wr_stb_o, wr_data_o, busy_o, err_o
    );
endinterface

// File: rtl/smi_target.sv
// Clause-22 MDIO target: oversamples MDC/MDIO, decodes frames addressed to
// PHY_ADDR, issues register read/write strobes and drives read data back on
// the open-drain MDIO line.
module smi_target #(
    parameter logic [4:0] PHY_ADDR = 5'd1,
    parameter int         PRE_MIN  = 32
) (
    input  logic       clk,
    input  logic       rst,
    smi_target_if.slave bus,
    output logic [2:0] state_dbg
);
    localparam logic [5:0] PRE_MIN_C = 6'(PRE_MIN);

    typedef enum logic [2:0] {
        S_PRE, S_ST1, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_SKIP
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  ones_q, ones_d;
    // Bit position within the 32-bit post-preamble frame; bit 0 is the ST '0'.
    logic [4:0]  fpos_q, fpos_d;
    logic        is_rd_q, is_rd_d;
    logic [15:0] sr_q, sr_d;
    logic [4:0]  adr_q, adr_d;
    logic [15:0] wdat_q, wdat_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic        rd_stb_q, rd_stb_d;
    logic        wr_stb_q, wr_stb_d;
    logic        err_q, err_d;

    logic mdc_s1, mdc_s2, mdc_d, mdio_s1, mdio_s2;
    logic bit_ev, b;

    // Two-flop synchronisers plus a delayed MDC copy for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdc_s1  <= 1'b0;
            mdc_s2  <= 1'b0;
            mdc_d   <= 1'b0;
            mdio_s1 <= 1'b1;
            mdio_s2 <= 1'b1;
        end else begin
            mdc_s1  <= bus.mdc_i;
            mdc_s2  <= mdc_s1;
            mdc_d   <= mdc_s2;
            mdio_s1 <= bus.mdio_i;
            mdio_s2 <= mdio_s1;
        end
    end

    assign bit_ev = mdc_s2 & ~mdc_d;
    assign b      = mdio_s2;

    // State and datapath registers; reset releases MDIO immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_PRE;
            ones_q   <= '0;
            fpos_q   <= '0;
            is_rd_q  <= 1'b0;
            sr_q     <= '0;
            adr_q    <= '0;
            wdat_q   <= '0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            rd_stb_q <= 1'b0;
            wr_stb_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ones_q   <= ones_d;
            fpos_q   <= fpos_d;
            is_rd_q  <= is_rd_d;
            sr_q     <= sr_d;
            adr_q    <= adr_d;
            wdat_q   <= wdat_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
            rd_stb_q <= rd_stb_d;
            wr_stb_q <= wr_stb_d;
            err_q    <= err_d;
        end
    end

    // Frame decoder: every change happens on an MDC bit event only.
    always_comb begin
        state_d  = state_q;
        ones_d   = ones_q;
        fpos_d   = fpos_q;
        is_rd_d  = is_rd_q;
        sr_d     = sr_q;
        adr_d    = adr_q;
        wdat_d   = wdat_q;
        oe_d     = oe_q;
        busy_d   = busy_q;
        rd_stb_d = 1'b0;
        wr_stb_d = 1'b0;
        err_d    = 1'b0;
        if (bit_ev) begin
            fpos_d = fpos_q + 5'd1;
            sr_d   = {sr_q[14:0], b};
            case (state_q)
                S_PRE: begin
                    if (b) begin
                        ones_d = (ones_q == 6'd63) ? ones_q : ones_q + 6'd1;
                    end else if (ones_q >= PRE_MIN_C) begin
                        state_d = S_ST1;
                        ones_d  = '0;
                        fpos_d  = 5'd1;
                    end else begin
                        ones_d = '0;
                    end
                end
                S_ST1: begin
                    if (b) begin
                        state_d = S_OP;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_PRE;
                        ones_d  = '0;
                    end
                end
                S_OP: begin
                    if (fpos_q == 5'd3) begin
                        if ({sr_q[0], b} == 2'b10) begin
                            is_rd_d = 1'b0;
                            state_d = S_PHYAD;
                        end else if ({sr_q[0], b} == 2'b01) begin
                            is_rd_d = 1'b1;
                            state_d = S_PHYAD;
                        end else begin
                            state_d = S_SKIP;
                        end
                    end
                end
                S_PHYAD: begin
                    if (fpos_q == 5'd8)
                        state_d = ({sr_q[3:0], b} == PHY_ADDR) ? S_REGAD : S_SKIP;
                end
                S_REGAD: begin
                    if (fpos_q == 5'd13) begin
                        adr_d    = {sr_q[3:0], b};
                        rd_stb_d = is_rd_q;
                        state_d  = S_TA;
                    end
                end
                S_TA: begin
                    if (is_rd_q) begin
                        if (fpos_q == 5'd14) begin
                            // Read data is fetched here and the 2nd TA bit is driven 0.
                            sr_d = bus.rd_data_i;
                            oe_d = 1'b1;
                        end else begin
                            sr_d    = sr_q;
                            oe_d    = ~sr_q[15];
                            state_d = S_DATA;
                        end
                    end else if (b != (fpos_q == 5'd14)) begin
                        err_d   = 1'b1;
                        state_d = S_SKIP;
                    end else if (fpos_q == 5'd15) begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (is_rd_q) begin
                        sr_d = {sr_q[14:0], 1'b0};
                        oe_d = ~sr_q[14];
                    end
                    if (fpos_q == 5'd31) begin
                        state_d = S_PRE;
                        ones_d  = '0;
                        busy_d  = 1'b0;
                        oe_d    = 1'b0;
                        fpos_d  = '0;
                        if (!is_rd_q) begin
                            wdat_d   = {sr_q[14:0], b};
                            wr_stb_d = 1'b1;
                        end
                    end
                end
                S_SKIP: begin
                    // Swallow the rest of the 32-bit frame body, then demand a new preamble.
                    oe_d = 1'b0;
                    if (fpos_q == 5'd31) begin
                        state_d = S_PRE;
                        ones_d  = '0;
                        busy_d  = 1'b0;
                        fpos_d  = '0;
                    end
                end
                default: state_d = S_PRE;
            endcase
        end
    end

    assign bus.mdio_oe_o = oe_q;
    assign bus.rd_stb_o  = rd_stb_q;
    assign bus.rd_adr_o  = adr_q;
    assign bus.wr_stb_o  = wr_stb_q;
    assign bus.wr_data_o = wdat_q;
    assign bus.busy_o    = busy_q;
    assign bus.err_o     = err_q;
    assign state_dbg     = 3'(state_q);
endmodule

// File: tb/tb_smi_target.sv
// Bench for smi_target: an MDIO station model drives frames; monitors pop
// expected strobes from queues and compare against the target's outputs.
module tb_smi_target;
    localparam time HALF = 40ns;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mdc = 1'b0;
    logic m_level = 1'b1;
    logic en1 = 1'b0;
    logic [15:0] rd_value = 16'h0;
    logic [15:0] rd_data0 = 16'h0;
    logic [2:0] st0, st1;

    int checks = 0;
    int failures = 0;
    int oe_cnt = 0;

    logic [20:0] exp_wr_q[$];
    logic [20:0] exp_wr1_q[$];
    logic [4:0]  exp_rd_q[$];
    logic        exp_err_q[$];

    smi_target_if bus0();
    smi_target_if bus1();

    assign bus0.mdc_i     = mdc;
    assign bus0.mdio_i    = m_level & ~bus0.mdio_oe_o;
    assign bus0.rd_data_i = rd_data0;
    assign bus1.mdc_i     = mdc & en1;
    assign bus1.mdio_i    = m_level & ~bus1.mdio_oe_o;
    assign bus1.rd_data_i = 16'h0;

    smi_target #(.PHY_ADDR(5'd1), .PRE_MIN(32)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .state_dbg(st0));
    smi_target #(.PHY_ADDR(5'd1), .PRE_MIN(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .state_dbg(st1));

    // clock
    always #5ns clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s: unexpected strobe, value %0h", name, act);
    endtask

    // Monitors / scoreboard, sampled on the falling clk edge.
    always @(negedge clk) begin
        if (rst) begin
            if (bus0.mdio_oe_o) oe_cnt++;
            if (bus0.rd_stb_o) rd_data0 = rd_value;
            if (bus0.wr_stb_o) begin
                if (exp_wr_q.size() == 0) unexpected("wr0", {11'h0, bus0.rd_adr_o, bus0.wr_data_o});
                else check("wr0", {11'h0, bus0.rd_adr_o, bus0.wr_data_o}, {11'h0, exp_wr_q.pop_front()});
            end
            if (bus0.rd_stb_o) begin
                if (exp_rd_q.size() == 0) unexpected("rd0", {27'h0, bus0.rd_adr_o});
                else check("rd0", {27'h0, bus0.rd_adr_o}, {27'h0, exp_rd_q.pop_front()});
            end
            if (bus0.err_o) begin
                if (exp_err_q.size() == 0) unexpected("err0", 32'h1);
                else check("err0", 32'h1, {31'h0, exp_err_q.pop_front()});
            end
            if (bus1.wr_stb_o) begin
                if (exp_wr1_q.size() == 0) unexpected("wr1", {11'h0, bus1.rd_adr_o, bus1.wr_data_o});
                else check("wr1", {11'h0, bus1.rd_adr_o, bus1.wr_data_o}, {11'h0, exp_wr1_q.pop_front()});
            end
            if (bus1.rd_stb_o) unexpected("rd1", {27'h0, bus1.rd_adr_o});
            if (bus1.err_o) unexpected("err1", 32'h1);
        end
    end

    // One MDC cycle; s is the line level the station sees at the rising edge.
    task automatic bit_out(input logic bv, output logic s);
        m_level = bv;
        #(HALF);
        mdc = 1'b1;
        s = bus0.mdio_i;
        #(HALF);
        mdc = 1'b0;
    endtask

    task automatic send_field(input logic [31:0] v, input int n);
        logic s;
        for (int i = n - 1; i >= 0; i--) bit_out(v[i], s);
    endtask

    task automatic send_ones(input int n);
        send_field(32'hFFFF_FFFF, n);
    endtask

    task automatic write_frame(input logic [4:0] phy, input logic [4:0] regad,
                               input logic [1:0] ta, input logic [15:0] data,
                               input bit check_busy);
        send_ones(32);
        send_field({16'h0, 2'b01, 2'b10, phy, regad, ta}, 16);
        if (check_busy) check("busy_mid_write", {31'h0, bus0.busy_o}, 32'h1);
        send_field({16'h0, data}, 16);
        m_level = 1'b1;
    endtask

    task automatic read_frame(input logic [4:0] phy, input logic [4:0] regad,
                              output logic [17:0] got);
        logic s;
        send_ones(32);
        send_field({18'h0, 2'b01, 2'b01, phy, regad}, 14);
        for (int i = 17; i >= 0; i--) begin
            bit_out(1'b1, s);
            got[i] = s;
        end
    endtask

    initial begin
        logic [17:0] got;

        // reset
        #22ns;
        check("rst_oe", {31'h0, bus0.mdio_oe_o}, 32'h0);
        check("rst_rd_stb", {31'h0, bus0.rd_stb_o}, 32'h0);
        check("rst_wr_stb", {31'h0, bus0.wr_stb_o}, 32'h0);
        check("rst_err", {31'h0, bus0.err_o}, 32'h0);
        check("rst_busy", {31'h0, bus0.busy_o}, 32'h0);
        check("rst_adr", {27'h0, bus0.rd_adr_o}, 32'h0);
        check("rst_wdata", {16'h0, bus0.wr_data_o}, 32'h0);
        check("rst_state", {29'h0, st0}, 32'h0);
        rst = 1'b1;
        #100ns;

        // plain write
        oe_cnt = 0;
        exp_wr_q.push_back({5'd5, 16'hA5C3});
        write_frame(5'd1, 5'd5, 2'b10, 16'hA5C3, 1'b1);
        #(HALF);
        check("write_busy_after", {31'h0, bus0.busy_o}, 32'h0);
        check("write_adr", {27'h0, bus0.rd_adr_o}, 32'h5);
        check("write_data", {16'h0, bus0.wr_data_o}, 32'hA5C3);
        check("write_no_drive", oe_cnt, 0);
        check("write_state_pre", {29'h0, st0}, 32'h0);

        // plain read
        rd_value = 16'h1234;
        exp_rd_q.push_back(5'd2);
        read_frame(5'd1, 5'd2, got);
        check("read_ta_data", {14'h0, got}, {14'h0, 2'b10, 16'h1234});
        #(HALF);
        check("read_released", {31'h0, bus0.mdio_oe_o}, 32'h0);
        check("read_busy_after", {31'h0, bus0.busy_o}, 32'h0);

        // wrong PHY address, then a valid read
        oe_cnt = 0;
        read_frame(5'd3, 5'd2, got);
        check("wrong_phy_line", {14'h0, got}, 32'h3FFFF);
        check("wrong_phy_no_drive", oe_cnt, 0);
        rd_value = 16'hBEEF;
        exp_rd_q.push_back(5'd7);
        read_frame(5'd1, 5'd7, got);
        check("after_wrong_read", {14'h0, got}, {14'h0, 2'b10, 16'hBEEF});

        // short preamble: ignored by PRE_MIN=32, accepted by PRE_MIN=1
        en1 = 1'b1;
        exp_wr1_q.push_back({5'd6, 16'h5AA5});
        send_ones(20);
        send_field({2'b01, 2'b10, 5'd1, 5'd6, 2'b10, 16'h5AA5}, 32);
        m_level = 1'b1;
        #(HALF);
        en1 = 1'b0;
        check("short_pre_wdata_kept", {16'h0, bus0.wr_data_o}, 32'hA5C3);
        check("short_pre_min1_data", {16'h0, bus1.wr_data_o}, 32'h5AA5);

        // bad turnaround on write
        exp_err_q.push_back(1'b1);
        write_frame(5'd1, 5'd8, 2'b11, 16'h1111, 1'b0);
        #(HALF);
        check("bad_ta_wdata_kept", {16'h0, bus0.wr_data_o}, 32'hA5C3);
        check("bad_ta_busy_after", {31'h0, bus0.busy_o}, 32'h0);

        // back-to-back writes
        exp_wr_q.push_back({5'd10, 16'h0001});
        exp_wr_q.push_back({5'd31, 16'hFFFF});
        write_frame(5'd1, 5'd10, 2'b10, 16'h0001, 1'b0);
        write_frame(5'd1, 5'd31, 2'b10, 16'hFFFF, 1'b0);
        #(HALF);
        check("b2b_last_data", {16'h0, bus0.wr_data_o}, 32'hFFFF);

        // reset in the middle of read data
        rd_value = 16'h0000;
        exp_rd_q.push_back(5'd4);
        send_ones(32);
        send_field({18'h0, 2'b01, 2'b01, 5'd1, 5'd4}, 14);
        send_field(32'h3FF, 10);
        check("mid_read_driving", {31'h0, bus0.mdio_oe_o}, 32'h1);
        rst = 1'b0;
        #1ns;
        check("async_rst_release", {31'h0, bus0.mdio_oe_o}, 32'h0);
        check("async_rst_busy", {31'h0, bus0.busy_o}, 32'h0);
        #20ns;
        rst = 1'b1;
        #20ns;
        oe_cnt = 0;
        send_ones(8);
        check("post_rst_no_drive", oe_cnt, 0);
        rd_value = 16'h5A0F;
        exp_rd_q.push_back(5'd9);
        read_frame(5'd1, 5'd9, got);
        check("post_rst_read", {14'h0, got}, {14'h0, 2'b10, 16'h5A0F});
        #(HALF);

        check("wr_q_drained", exp_wr_q.size(), 0);
        check("wr1_q_drained", exp_wr1_q.size(), 0);
        check("rd_q_drained", exp_rd_q.size(), 0);
        check("err_q_drained", exp_err_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
